// File: rtl/count_updn_mod_if.sv
// count_updn_mod_if: control and status bundle for the up/down modulo counter.
//   master modport : drives en, up_dn, sat_mode, load, load_val, max_val;
//                    observes count, tc, wrap, wrap_cnt.
//   slave modport  : the counter side (inputs and outputs reversed).
// Handshake: there is no valid/ready pair. Every control input is sampled on
// each rising clock edge. count, wrap and wrap_cnt change one edge after
// sampling. tc follows the current inputs combinationally.
interface count_updn_mod_if #(
  parameter int WIDTH = 32,
  parameter int EVW   = 8
);
  logic             en;
  logic             up_dn;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic [EVW-1:0]   wrap_cnt;

  modport master (
    output en, up_dn, sat_mode, load, load_val, max_val,
    input  count, tc, wrap, wrap_cnt
  );

  modport slave (
    input  en, up_dn, sat_mode, load, load_val, max_val,
    output count, tc, wrap, wrap_cnt
  );
endinterface

// File: rtl/count_updn_mod.sv
// count_updn_mod: parametrised up/down counter with a modulo bound, wrap or
// saturate mode, parallel load, terminal-count flag and a wrap-event tally.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, overrides every other input
//   bus  : count_updn_mod_if slave modport
//          inputs  en, up_dn, sat_mode, load, load_val, max_val
//          outputs count (registered), tc (combinational),
//                  wrap (registered pulse), wrap_cnt (registered, saturating)
// Priority each cycle: rst > load > en > hold.
module count_updn_mod #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               EVW     = 8
) (
  input logic              clk,
  input logic              rst,
  count_updn_mod_if.slave  bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [EVW-1:0]   wrap_cnt_q, wrap_cnt_d;

  logic at_max;
  logic at_zero;
  logic over_max;
  logic wrap_evt;

  assign at_max   = (count_q == bus.max_val);
  assign at_zero  = (count_q == '0);
  // count can exceed the bound only when max_val is lowered while counting.
  assign over_max = (count_q > bus.max_val);

  always_comb begin
    count_d    = count_q;
    wrap_evt   = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
    end else if (bus.en) begin
      if (over_max) begin
        // Pull back into range; this correction is not a wrap.
        count_d = bus.max_val;
      end else if (bus.up_dn) begin
        if (at_max) begin
          if (!bus.sat_mode) begin
            count_d  = '0;
            wrap_evt = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          if (!bus.sat_mode) begin
            count_d  = bus.max_val;
            wrap_evt = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    wrap_d     = wrap_evt;
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_evt && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= RST_VAL;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  // tc ignores sat_mode: it flags that the next enabled step sits on a bound.
  assign bus.tc       = bus.en & ~bus.load &
                        ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));
  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_count_updn_mod.sv
module tb_count_updn_mod;

  localparam int W = 41;  // {count[31:0], wrap, wrap_cnt[7:0]}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  count_updn_mod_if #(.WIDTH(32), .EVW(8)) a_if ();
  count_updn_mod_if #(.WIDTH(8),  .EVW(2)) b_if ();

  count_updn_mod #(.WIDTH(32), .RST_VAL(32'd0), .EVW(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  count_updn_mod #(.WIDTH(8), .RST_VAL(8'd0), .EVW(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock step: drive inputs on the selected instance (the other idles),
  // check tc before the edge, queue the expected registered outputs, then
  // pop and compare them just after the edge.
  task automatic step(input bit sel, input logic r, input logic e, input logic u,
                      input logic s, input logic l, input logic [31:0] lv,
                      input logic [31:0] mv, input logic [31:0] ec,
                      input logic ew, input logic [7:0] ewc, input logic etc,
                      input string tag);
    logic [W-1:0] exp_v;
    logic [31:0]  o_count;
    logic         o_wrap;
    logic [7:0]   o_wc;
    logic         o_tc;
    rst = r;
    if (!sel) begin
      a_if.en = e; a_if.up_dn = u; a_if.sat_mode = s; a_if.load = l;
      a_if.load_val = lv; a_if.max_val = mv;
      b_if.en = 1'b0; b_if.load = 1'b0;
    end else begin
      b_if.en = e; b_if.up_dn = u; b_if.sat_mode = s; b_if.load = l;
      b_if.load_val = lv[7:0]; b_if.max_val = mv[7:0];
      a_if.en = 1'b0; a_if.load = 1'b0;
    end
    #1;
    o_tc = sel ? b_if.tc : a_if.tc;
    chk({tag, ".tc"}, {31'd0, o_tc}, {31'd0, etc});
    exp_q.push_back({ec, ew, ewc});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp_v = exp_q.pop_front();
      if (!sel) begin
        o_count = a_if.count; o_wrap = a_if.wrap; o_wc = a_if.wrap_cnt;
      end else begin
        o_count = {24'd0, b_if.count}; o_wrap = b_if.wrap; o_wc = {6'd0, b_if.wrap_cnt};
      end
      chk({tag, ".count"}, o_count, exp_v[40:9]);
      chk({tag, ".wrap"}, {31'd0, o_wrap}, {31'd0, exp_v[8]});
      chk({tag, ".wrap_cnt"}, {24'd0, o_wc}, {24'd0, exp_v[7:0]});
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    a_if.en = 1'b0; a_if.up_dn = 1'b1; a_if.sat_mode = 1'b0; a_if.load = 1'b0;
    a_if.load_val = '0; a_if.max_val = '1;
    b_if.en = 1'b0; b_if.up_dn = 1'b1; b_if.sat_mode = 1'b0; b_if.load = 1'b0;
    b_if.load_val = '0; b_if.max_val = '0;
    @(posedge clk);
    #1;

    // Reset for two cycles
    step(0, 1, 0, 1, 0, 0, 32'd0, 32'hFFFF_FFFF, 32'd0, 0, 8'd0, 0, "reset0");
    step(0, 1, 0, 1, 0, 0, 32'd0, 32'hFFFF_FFFF, 32'd0, 0, 8'd0, 0, "reset1");

    // Free-run as a plain 32-bit binary counter
    for (int i = 1; i <= 10; i++)
      step(0, 0, 1, 1, 0, 0, 32'd0, 32'hFFFF_FFFF, i, 0, 8'd0, 0, "freerun");

    // Modulo-5 wrap: counts 0..4 then back to 0
    step(0, 0, 0, 1, 0, 1, 32'd0, 32'd4, 32'd0, 0, 8'd0, 0, "mod5_load");
    for (int k = 1; k <= 12; k++)
      step(0, 0, 1, 1, 0, 0, 32'd0, 32'd4, k % 5, (k % 5) == 0, k / 5,
           ((k - 1) % 5) == 4, "mod5");

    // Down with saturation at zero
    step(0, 0, 0, 0, 1, 1, 32'd2, 32'd4, 32'd2, 0, 8'd2, 0, "down_load");
    step(0, 0, 1, 0, 1, 0, 32'd0, 32'd4, 32'd1, 0, 8'd2, 0, "down_sat1");
    step(0, 0, 1, 0, 1, 0, 32'd0, 32'd4, 32'd0, 0, 8'd2, 0, "down_sat2");
    step(0, 0, 1, 0, 1, 0, 32'd0, 32'd4, 32'd0, 0, 8'd2, 1, "down_sat3");
    step(0, 0, 1, 0, 1, 0, 32'd0, 32'd4, 32'd0, 0, 8'd2, 1, "down_sat4");
    step(0, 0, 1, 0, 1, 0, 32'd0, 32'd4, 32'd0, 0, 8'd2, 1, "down_sat5");

    // Load clamps to max_val and wins over en
    step(0, 0, 1, 1, 0, 1, 32'd20, 32'd9, 32'd9, 0, 8'd2, 0, "load_clamp");
    // Reset wins over load
    step(0, 1, 0, 1, 0, 1, 32'd7, 32'd9, 32'd0, 0, 8'd0, 0, "rst_over_load");

    // max_val lowered below count: clamp without wrap, then wrap
    step(0, 0, 0, 1, 0, 1, 32'd7, 32'd9, 32'd7, 0, 8'd0, 0, "lower_load");
    step(0, 0, 1, 1, 0, 0, 32'd0, 32'd3, 32'd3, 0, 8'd0, 0, "lower_clamp");
    step(0, 0, 1, 1, 0, 0, 32'd0, 32'd3, 32'd0, 1, 8'd1, 1, "lower_wrap");
    // Down wrap from zero to max_val, then idle
    step(0, 0, 1, 0, 0, 0, 32'd0, 32'd3, 32'd3, 1, 8'd2, 1, "down_wrap");
    step(0, 0, 0, 0, 0, 0, 32'd0, 32'd3, 32'd3, 0, 8'd2, 0, "idle");

    // Narrow tally: max_val=0 in wrap mode wraps every cycle, tally saturates at 3
    step(1, 0, 1, 1, 0, 0, 32'd0, 32'd0, 32'd0, 1, 8'd1, 1, "wc_sat1");
    step(1, 0, 1, 1, 0, 0, 32'd0, 32'd0, 32'd0, 1, 8'd2, 1, "wc_sat2");
    step(1, 0, 1, 1, 0, 0, 32'd0, 32'd0, 32'd0, 1, 8'd3, 1, "wc_sat3");
    step(1, 0, 1, 1, 0, 0, 32'd0, 32'd0, 32'd0, 1, 8'd3, 1, "wc_sat4");
    step(1, 0, 1, 1, 0, 0, 32'd0, 32'd0, 32'd0, 1, 8'd3, 1, "wc_sat5");
    step(1, 0, 1, 1, 0, 0, 32'd0, 32'd0, 32'd0, 1, 8'd3, 1, "wc_sat6");
    // Same bound in saturate mode: no wrap event, tc still high
    step(1, 0, 1, 1, 1, 0, 32'd0, 32'd0, 32'd0, 0, 8'd3, 1, "max0_sat");

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      chk("leftover_expected", exp_q.size(), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
